writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage, directly downstream of the memory stage. Accepts one instruction per handshake, writes its primary result and optional special result (e.g. RDX half of MUL/DIV) to the register file through a single write port, clears scoreboard bits, and retires the instruction. A two-result instruction takes two write cycles; the stage back-pressures memory with `canWritebackOut`, which drives the memory stage's `canMemoryIn`.

## Interface
- `RETIRE_CNT_WIDTH`, 32, width of retired-instruction counter.
- `HALT_OPCODE`, 8'hF4, opcode that sets the sticky halt flag on retirement.

- `clk` in 1 — single clock; all state updates on rising edge.
- `reset` in 1 — synchronous, active-high.
- `isMemorySuccessfulIn` in 1 — memory stage holds a valid instruction.
- `currentRipIn` in 64 — RIP of the instruction.
- `opcodeIn` in 8 — primary opcode byte.
- `operand1ValIn` in 64 — primary result.
- `operand2ValIn` in 64 — special result.
- `destRegIn` in 4 — primary destination.
- `destRegValidIn` in 1 — primary destination present.
- `destRegSpecialIn` in 4 — special destination.
- `destRegSpecialValidIn` in 1 — special destination present.
- `canWritebackOut` out 1 — stage accepts an instruction this cycle.
- `regWriteEnOut` out 1 — register-file write strobe.
- `regWriteAddrOut` out 4 — write address.
- `regWriteDataOut` out 64 — write data.
- `scoreboardClearOut` out 16 — one-hot clear mask for the register written this cycle.
- `retireValidOut` out 1 — one-cycle pulse on retirement.
- `retiredRipOut` out 64 — RIP of retiring instruction.
- `retireCountOut` out RETIRE_CNT_WIDTH — retired-instruction count.
- `haltOut` out 1 — sticky halt.

## Operation
- States: IDLE, WRITE_PRI, WRITE_SPC.
- Accept = `isMemorySuccessfulIn && canWritebackOut`; latches rip, opcode, both values, both destinations and valids.
- `canWritebackOut` = IDLE, or WRITE_PRI with latched special valid = 0, or WRITE_SPC; forced 0 while `haltOut`=1.
- IDLE: accept → WRITE_PRI; else stay.
- WRITE_PRI: `regWriteEnOut` = latched destRegValid, addr = destReg, data = primary value, clear mask = one-hot(destReg) if valid else 0. If special valid → WRITE_SPC. Else retire; accept → WRITE_PRI, else → IDLE.
- WRITE_SPC: `regWriteEnOut`=1, addr = destRegSpecial, data = special value, one-hot clear. Retire; accept → WRITE_PRI, else → IDLE.
- Retire cycle: `retireValidOut`=1, `retiredRipOut` = latched rip; counter increments at that cycle's edge, wraps from all-ones to 0. If latched opcode == HALT_OPCODE, `haltOut` sets at that edge and holds until reset.
- No primary and no special destination: one WRITE_PRI cycle with write enable 0, still retires.
- Primary and special destination equal: both writes issue in order; special value wins.

## Timing
- All outputs decoded from registered state/latches only; no input-to-output combinational path except `canWritebackOut`'s halt/state terms (none from inputs).
- Accept at edge N → write visible cycle N+1 → retire pulse in N+1 (single) or N+2 (special).
- Throughput: 1 instr/cycle single-result; 1 per 2 cycles two-result.
- Reset: state IDLE, all latches 0, `regWriteEnOut`=0, `scoreboardClearOut`=0, `retireValidOut`=0, `retiredRipOut`=0, `retireCountOut`=0, `haltOut`=0, `canWritebackOut`=1 the cycle after reset deasserts. Reset mid-WRITE_SPC drops the pending special write and the retirement.
- Halt: retiring HLT blocks further accepts from the next cycle; an instruction accepted in the same cycle as HLT retires is still written and retired.

## Configuration
- `WB_RETIRE_COUNT_EN`: defined → counter as above. Undefined → counter logic omitted, `retireCountOut` tied to 0; all other behaviour identical.

## Test plan
- Single-result stream: 3 back-to-back instrs dest R1,R2,R3 values 0x11,0x22,0x33 → writes on consecutive cycles, masks 0x0002,0x0004,0x0008, count 3, `canWritebackOut` never low.
- MUL-style: dest R0=0xA, special R2=0xB → writes R0 then R2 over 2 cycles, `canWritebackOut`=0 during WRITE_PRI, one retire pulse in second cycle.
- No-destination instr (CMP) rip 0x400000 → no write, mask 0, retire pulse with rip 0x400000.
- HLT (0xF4) followed by valid instr held on input → `haltOut`=1 next cycle, `canWritebackOut` stays 0, no further writes until reset.
- Reset asserted in WRITE_SPC → special write never issues, count 0, `haltOut`=0, IDLE.
- With `WB_RETIRE_COUNT_EN` and RETIRE_CNT_WIDTH=4: 17 retirements → count 1 (wrap).

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: writes primary/special results through one register-file port,
// clears scoreboard bits and retires. Optional retire counter enabled by WB_RETIRE_COUNT_EN.
module writeback_stage #(
    parameter int unsigned RETIRE_CNT_WIDTH = 32,
    parameter logic [7:0]  HALT_OPCODE      = 8'hF4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        isMemorySuccessfulIn,
    input  logic [63:0]                 currentRipIn,
    input  logic [7:0]                  opcodeIn,
    input  logic [63:0]                 operand1ValIn,
    input  logic [63:0]                 operand2ValIn,
    input  logic [3:0]                  destRegIn,
    input  logic                        destRegValidIn,
    input  logic [3:0]                  destRegSpecialIn,
    input  logic                        destRegSpecialValidIn,
    output logic                        canWritebackOut,
    output logic                        regWriteEnOut,
    output logic [3:0]                  regWriteAddrOut,
    output logic [63:0]                 regWriteDataOut,
    output logic [15:0]                 scoreboardClearOut,
    output logic                        retireValidOut,
    output logic [63:0]                 retiredRipOut,
    output logic [RETIRE_CNT_WIDTH-1:0] retireCountOut,
    output logic                        haltOut
);

    typedef enum logic [1:0] {
        StIdle,
        StWritePri,
        StWriteSpc
    } state_e;

    state_e state_q, state_d;

    logic [63:0] rip_q, rip_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [63:0] pri_val_q, pri_val_d;
    logic [63:0] spc_val_q, spc_val_d;
    logic [3:0]  pri_dest_q, pri_dest_d;
    logic        pri_valid_q, pri_valid_d;
    logic [3:0]  spc_dest_q, spc_dest_d;
    logic        spc_valid_q, spc_valid_d;
    logic        halt_q, halt_d;

    logic can_accept;
    logic accept;
    logic retire;

    function automatic logic [15:0] one_hot(input logic [3:0] idx);
        one_hot = 16'h0001 << idx;
    endfunction

    // Stage is free when idle or when the current instruction retires this cycle.
    always_comb begin
        can_accept = 1'b0;
        retire     = 1'b0;
        unique case (state_q)
            StIdle: begin
                can_accept = 1'b1;
            end
            StWritePri: begin
                can_accept = !spc_valid_q;
                retire     = !spc_valid_q;
            end
            StWriteSpc: begin
                can_accept = 1'b1;
                retire     = 1'b1;
            end
            default: begin
                can_accept = 1'b0;
                retire     = 1'b0;
            end
        endcase
    end

    assign canWritebackOut = can_accept && !halt_q;
    assign accept          = isMemorySuccessfulIn && canWritebackOut;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StWritePri;
            end
            StWritePri: begin
                if (spc_valid_q) begin
                    state_d = StWriteSpc;
                end else if (accept) begin
                    state_d = StWritePri;
                end else begin
                    state_d = StIdle;
                end
            end
            StWriteSpc: begin
                state_d = accept ? StWritePri : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Instruction latches load on every accept and hold otherwise.
    always_comb begin
        rip_d       = rip_q;
        opcode_d    = opcode_q;
        pri_val_d   = pri_val_q;
        spc_val_d   = spc_val_q;
        pri_dest_d  = pri_dest_q;
        pri_valid_d = pri_valid_q;
        spc_dest_d  = spc_dest_q;
        spc_valid_d = spc_valid_q;
        if (accept) begin
            rip_d       = currentRipIn;
            opcode_d    = opcodeIn;
            pri_val_d   = operand1ValIn;
            spc_val_d   = operand2ValIn;
            pri_dest_d  = destRegIn;
            pri_valid_d = destRegValidIn;
            spc_dest_d  = destRegSpecialIn;
            spc_valid_d = destRegSpecialValidIn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rip_q       <= '0;
            opcode_q    <= '0;
            pri_val_q   <= '0;
            spc_val_q   <= '0;
            pri_dest_q  <= '0;
            pri_valid_q <= 1'b0;
            spc_dest_q  <= '0;
            spc_valid_q <= 1'b0;
        end else begin
            rip_q       <= rip_d;
            opcode_q    <= opcode_d;
            pri_val_q   <= pri_val_d;
            spc_val_q   <= spc_val_d;
            pri_dest_q  <= pri_dest_d;
            pri_valid_q <= pri_valid_d;
            spc_dest_q  <= spc_dest_d;
            spc_valid_q <= spc_valid_d;
        end
    end

    // Halt is sticky until reset.
    always_comb begin
        halt_d = halt_q;
        if (retire && (opcode_q == HALT_OPCODE)) halt_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign haltOut = halt_q;

`ifdef WB_RETIRE_COUNT_EN
    localparam logic [RETIRE_CNT_WIDTH-1:0] CntOne = RETIRE_CNT_WIDTH'(1);

    logic [RETIRE_CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire) retire_cnt_d = retire_cnt_q + CntOne;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retireCountOut = retire_cnt_q;
`else
    assign retireCountOut = '0;
`endif

    // Output decode from registered state and latches only.
    always_comb begin
        regWriteEnOut      = 1'b0;
        regWriteAddrOut    = '0;
        regWriteDataOut    = '0;
        scoreboardClearOut = '0;
        retireValidOut     = retire;
        retiredRipOut      = retire ? rip_q : 64'h0;
        unique case (state_q)
            StIdle: begin
                regWriteEnOut = 1'b0;
            end
            StWritePri: begin
                regWriteEnOut      = pri_valid_q;
                regWriteAddrOut    = pri_dest_q;
                regWriteDataOut    = pri_val_q;
                scoreboardClearOut = pri_valid_q ? one_hot(pri_dest_q) : 16'h0000;
            end
            StWriteSpc: begin
                regWriteEnOut      = 1'b1;
                regWriteAddrOut    = spc_dest_q;
                regWriteDataOut    = spc_val_q;
                scoreboardClearOut = one_hot(spc_dest_q);
            end
            default: begin
                regWriteEnOut = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a cycle table for the main stream plus hand-written
// sequences for reset-in-flight, equal destinations and counter wrap.
module tb_writeback_stage;

    localparam int unsigned CW = 4;
`ifdef WB_RETIRE_COUNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          vld;
    logic [63:0]   rip;
    logic [7:0]    opc;
    logic [63:0]   v1, v2;
    logic [3:0]    d, ds;
    logic          dv, dsv;
    logic          can, we, ret, halt;
    logic [3:0]    waddr;
    logic [63:0]   wdata, rrip;
    logic [15:0]   clr;
    logic [CW-1:0] cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    writeback_stage #(
        .RETIRE_CNT_WIDTH(CW),
        .HALT_OPCODE     (8'hF4)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .isMemorySuccessfulIn (vld),
        .currentRipIn         (rip),
        .opcodeIn             (opc),
        .operand1ValIn        (v1),
        .operand2ValIn        (v2),
        .destRegIn            (d),
        .destRegValidIn       (dv),
        .destRegSpecialIn     (ds),
        .destRegSpecialValidIn(dsv),
        .canWritebackOut      (can),
        .regWriteEnOut        (we),
        .regWriteAddrOut      (waddr),
        .regWriteDataOut      (wdata),
        .scoreboardClearOut   (clr),
        .retireValidOut       (ret),
        .retiredRipOut        (rrip),
        .retireCountOut       (cnt),
        .haltOut              (halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [63:0] rip;
        logic [7:0]  op;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [3:0]  d;
        logic        dv;
        logic [3:0]  ds;
        logic        dsv;
        logic        e_can;
        logic        e_we;
        logic [3:0]  e_addr;
        logic [63:0] e_data;
        logic [15:0] e_clr;
        logic        e_ret;
        logic [63:0] e_rip;
        logic [3:0]  e_cnt;
        logic        e_halt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a_vld, input logic [63:0] a_rip, input logic [7:0] a_op,
                         input logic [63:0] a_v1, input logic [63:0] a_v2,
                         input logic [3:0] a_d, input logic a_dv,
                         input logic [3:0] a_ds, input logic a_dsv);
        vld = a_vld; rip = a_rip; opc = a_op; v1 = a_v1; v2 = a_v2;
        d = a_d; dv = a_dv; ds = a_ds; dsv = a_dsv;
    endtask

    function automatic logic [63:0] exp_cnt(input logic [3:0] c);
        return CntEn ? 64'(c) : 64'h0;
    endfunction

    task automatic do_reset();
        drive(1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        vecs[0] = '{1'b1, 64'h1000, 8'h01, 64'h11, 64'h0, 4'd1, 1'b1, 4'd0, 1'b0,
                    1'b1, 1'b1, 4'd1, 64'h11, 16'h0002, 1'b1, 64'h1000, 4'd0, 1'b0};
        vecs[1] = '{1'b1, 64'h1004, 8'h01, 64'h22, 64'h0, 4'd2, 1'b1, 4'd0, 1'b0,
                    1'b1, 1'b1, 4'd2, 64'h22, 16'h0004, 1'b1, 64'h1004, 4'd1, 1'b0};
        vecs[2] = '{1'b1, 64'h1008, 8'h01, 64'h33, 64'h0, 4'd3, 1'b1, 4'd0, 1'b0,
                    1'b1, 1'b1, 4'd3, 64'h33, 16'h0008, 1'b1, 64'h1008, 4'd2, 1'b0};
        // MUL-style: primary R0, special R2; CMP held on input while stalled
        vecs[3] = '{1'b1, 64'h2000, 8'hF7, 64'hA, 64'hB, 4'd0, 1'b1, 4'd2, 1'b1,
                    1'b0, 1'b1, 4'd0, 64'hA, 16'h0001, 1'b0, 64'h0, 4'd3, 1'b0};
        vecs[4] = '{1'b1, 64'h400000, 8'h39, 64'h0, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0,
                    1'b1, 1'b1, 4'd2, 64'hB, 16'h0004, 1'b1, 64'h2000, 4'd3, 1'b0};
        vecs[5] = '{1'b1, 64'h400000, 8'h39, 64'h0, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0,
                    1'b1, 1'b0, 4'd0, 64'h0, 16'h0000, 1'b1, 64'h400000, 4'd4, 1'b0};
        // HLT, then an instruction accepted as HLT retires, then one that must be blocked
        vecs[6] = '{1'b1, 64'h3000, 8'hF4, 64'h0, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0,
                    1'b1, 1'b0, 4'd0, 64'h0, 16'h0000, 1'b1, 64'h3000, 4'd5, 1'b0};
        vecs[7] = '{1'b1, 64'h3004, 8'h01, 64'h55, 64'h0, 4'd5, 1'b1, 4'd0, 1'b0,
                    1'b0, 1'b1, 4'd5, 64'h55, 16'h0020, 1'b1, 64'h3004, 4'd6, 1'b1};
        vecs[8] = '{1'b1, 64'h3008, 8'h01, 64'h66, 64'h0, 4'd6, 1'b1, 4'd0, 1'b0,
                    1'b0, 1'b0, 4'd0, 64'h0, 16'h0000, 1'b0, 64'h0, 4'd7, 1'b1};
        vecs[9] = vecs[8];

        reset = 1'b1;
        drive(1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_can", 64'(can), 64'h1);
        chk("rst_we", 64'(we), 64'h0);
        chk("rst_clr", 64'(clr), 64'h0);
        chk("rst_ret", 64'(ret), 64'h0);
        chk("rst_rip", rrip, 64'h0);
        chk("rst_cnt", 64'(cnt), 64'h0);
        chk("rst_halt", 64'(halt), 64'h0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].vld, vecs[i].rip, vecs[i].op, vecs[i].v1, vecs[i].v2,
                  vecs[i].d, vecs[i].dv, vecs[i].ds, vecs[i].dsv);
            step();
            chk($sformatf("v%0d_can", i), 64'(can), 64'(vecs[i].e_can));
            chk($sformatf("v%0d_we", i), 64'(we), 64'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_addr", i), 64'(waddr), 64'(vecs[i].e_addr));
                chk($sformatf("v%0d_data", i), wdata, vecs[i].e_data);
            end
            chk($sformatf("v%0d_clr", i), 64'(clr), 64'(vecs[i].e_clr));
            chk($sformatf("v%0d_ret", i), 64'(ret), 64'(vecs[i].e_ret));
            if (vecs[i].e_ret) chk($sformatf("v%0d_rip", i), rrip, vecs[i].e_rip);
            chk($sformatf("v%0d_cnt", i), 64'(cnt), exp_cnt(vecs[i].e_cnt));
            chk($sformatf("v%0d_halt", i), 64'(halt), 64'(vecs[i].e_halt));
        end

        // Reset while the special write is pending: it must never issue.
        do_reset();
        chk("rs_halt0", 64'(halt), 64'h0);
        drive(1'b1, 64'h5000, 8'hF7, 64'h44, 64'h55, 4'd4, 1'b1, 4'd5, 1'b1);
        step();
        chk("rs_pri_we", 64'(we), 64'h1);
        chk("rs_pri_addr", 64'(waddr), 64'h4);
        drive(1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
        step();
        chk("rs_we", 64'(we), 64'h0);
        chk("rs_ret", 64'(ret), 64'h0);
        reset = 1'b0;
        step();
        chk("rs_we2", 64'(we), 64'h0);
        chk("rs_ret2", 64'(ret), 64'h0);
        chk("rs_cnt", 64'(cnt), 64'h0);
        chk("rs_halt", 64'(halt), 64'h0);
        chk("rs_can", 64'(can), 64'h1);

        // Primary and special destination equal: both writes in order, special last.
        drive(1'b1, 64'h6000, 8'hF7, 64'h1, 64'h2, 4'd3, 1'b1, 4'd3, 1'b1);
        step();
        drive(1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0);
        chk("eq_pri_we", 64'(we), 64'h1);
        chk("eq_pri_data", wdata, 64'h1);
        chk("eq_pri_ret", 64'(ret), 64'h0);
        step();
        chk("eq_spc_we", 64'(we), 64'h1);
        chk("eq_spc_addr", 64'(waddr), 64'h3);
        chk("eq_spc_data", wdata, 64'h2);
        chk("eq_spc_clr", 64'(clr), 64'h0008);
        chk("eq_spc_ret", 64'(ret), 64'h1);
        chk("eq_spc_rip", rrip, 64'h6000);
        step();
        chk("eq_idle_we", 64'(we), 64'h0);
        chk("eq_idle_ret", 64'(ret), 64'h0);
        chk("eq_cnt", 64'(cnt), exp_cnt(4'd1));

        // 17 back-to-back retirements wrap a 4-bit counter to 1.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 64'(32'h7000 + k * 4), 8'h01, 64'(k), 64'h0, 4'(k), 1'b1, 4'd0, 1'b0);
            step();
            chk($sformatf("wr%0d_can", k), 64'(can), 64'h1);
            chk($sformatf("wr%0d_ret", k), 64'(ret), 64'h1);
        end
        drive(1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        chk("wrap_cnt", 64'(cnt), exp_cnt(4'd1));
        chk("wrap_ret", 64'(ret), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
